// File: rtl/pipeline_coproc0.sv
// pipeline_coproc0: MIPS32 CP0 responder holding Status/Cause/EPC, arbitrating exceptions and IRQs.
// Optional Count/Compare timer is enabled by defining COPROC0_TIMER_EN.
module pipeline_coproc0 #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          N_IRQ      = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mc0,
    input  logic             i_we,
    input  logic [4:0]       i_addr,
    input  logic [31:0]      i_wdata,
    input  logic             i_invalid_instr,
    input  logic             i_eret,
    input  logic             i_overflow,
    input  logic [31:0]      i_pc,
    input  logic [N_IRQ-1:0] i_irq,
    output logic             o_interrupt,
    output logic [31:0]      o_vector,
    output logic [31:0]      o_epc,
    output logic [31:0]      o_rdata,
    output logic             o_exl
);
    typedef enum logic [1:0] {RUN, TAKE, HANDLER, RET} state_t;
    state_t      state_q, state_d;
    logic [7:0]  im_q, im_d;
    logic        ie_q, ie_d, exl_q, exl_d;
    logic [7:2]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  ip_eff;
    logic        accept, tmr_pend;
    logic        wr_status;
    assign wr_status = i_we && i_addr == 5'd12;
    assign ip_eff    = {ip_q[7] | tmr_pend, ip_q[6:2], 2'b00};
    assign accept    = state_q == RUN && !exl_q &&
                       (i_invalid_instr || i_overflow || (ie_q && |(ip_eff & im_q)));
`ifdef COPROC0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        pend_q, pend_d, moved_q;
    assign tmr_pend = pend_q;
    // Free-running counter; a match latches a sticky pending bit cleared only by writing Compare.
    always_comb begin
        count_d   = (i_we && i_addr == 5'd9) ? i_wdata : count_q + 32'd1;
        compare_d = (i_we && i_addr == 5'd11) ? i_wdata : compare_q;
        pend_d    = (i_we && i_addr == 5'd11) ? 1'b0 : pend_q | (moved_q && count_q == compare_q);
    end
    // Timer state; moved_q suppresses the trivial 0==0 match straight out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            pend_q    <= 1'b0;
            moved_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
            moved_q   <= 1'b1;
        end
    end
`else
    assign tmr_pend = 1'b0;
`endif
    // Next-state for the FSM and architectural registers; accept wins over mtc0, eret clears EXL last.
    always_comb begin
        logic [5:0] irq_ext;
        irq_ext          = '0;
        irq_ext[N_IRQ-1:0] = i_irq;
        ip_d    = irq_ext;
        im_d    = wr_status ? i_wdata[15:8] : im_q;
        ie_d    = wr_status ? i_wdata[0] : ie_q;
        exl_d   = wr_status ? i_wdata[1] : exl_q;
        epc_d   = (i_we && i_addr == 5'd14) ? i_wdata : epc_q;
        exc_d   = exc_q;
        state_d = state_q;
        if (accept) begin
            exl_d = 1'b1;
            epc_d = i_pc;
            exc_d = i_invalid_instr ? 5'd10 : i_overflow ? 5'd12 : 5'd0;
        end
        if (i_eret && exl_q)
            exl_d = 1'b0;
        case (state_q)
            RUN:     state_d = accept ? TAKE : RUN;
            TAKE:    state_d = HANDLER;
            HANDLER: state_d = i_eret ? RET : HANDLER;
            default: state_d = RUN;
        endcase
    end
    // State and register file, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            im_q    <= '0;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            ip_q    <= '0;
            exc_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            ip_q    <= ip_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
        end
    end
    // mfc0 read mux, combinational so it shows the value before any same-edge write.
    always_comb begin
        o_rdata = '0;
        if (i_mc0) begin
            case (i_addr)
                5'd12:   o_rdata = {16'h0, im_q, 6'b0, exl_q, ie_q};
                5'd13:   o_rdata = {16'h0, ip_eff, 1'b0, exc_q, 2'b00};
                5'd14:   o_rdata = epc_q;
`ifdef COPROC0_TIMER_EN
                5'd9:    o_rdata = count_q;
                5'd11:   o_rdata = compare_q;
`endif
                default: o_rdata = '0;
            endcase
        end
    end
    assign o_interrupt = state_q == TAKE;
    assign o_vector    = EXC_VECTOR;
    assign o_epc       = epc_q;
    assign o_exl       = exl_q;
endmodule

// File: tb/tb_pipeline_coproc0.sv
// tb_pipeline_coproc0: directed self-checking bench for pipeline_coproc0.
module tb_pipeline_coproc0;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mc0 = 0, we = 0, invalid = 0, eret = 0, overflow = 0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0, pc = '0;
    logic [5:0]  irq = '0;
    logic        o_interrupt, o_exl;
    logic [31:0] o_vector, o_epc, o_rdata;
    int tests = 0, fails = 0;

    pipeline_coproc0 dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mc0(mc0), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .i_invalid_instr(invalid), .i_eret(eret), .i_overflow(overflow), .i_pc(pc), .i_irq(irq),
        .o_interrupt(o_interrupt), .o_vector(o_vector), .o_epc(o_epc), .o_rdata(o_rdata), .o_exl(o_exl)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        mc0 = 1; addr = a;
        #1;
        d = o_rdata;
        mc0 = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1; addr = a; wdata = d;
        cyc;
        we = 0;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cyc;
        rd(12, r); if (r !== 32'h0) begin fails++; $display("FAIL reset_status got %h exp 0", r); end tests++;
        rd(13, r); if (r !== 32'h0) begin fails++; $display("FAIL reset_cause got %h exp 0", r); end tests++;
        rd(14, r); if (r !== 32'h0) begin fails++; $display("FAIL reset_epc got %h exp 0", r); end tests++;
        if (o_interrupt !== 1'b0) begin fails++; $display("FAIL reset_int got %b exp 0", o_interrupt); end tests++;
        if (o_exl !== 1'b0) begin fails++; $display("FAIL reset_exl got %b exp 0", o_exl); end tests++;
        if (o_vector !== 32'h180) begin fails++; $display("FAIL reset_vector got %h exp 180", o_vector); end tests++;
    endtask

    task automatic test_sync_exc;
        logic [31:0] r;
        invalid = 1; overflow = 1; pc = 32'h400;
        cyc;
        invalid = 0; overflow = 0;
        if (o_interrupt !== 1'b1) begin fails++; $display("FAIL sync_pulse got %b exp 1", o_interrupt); end tests++;
        if (o_epc !== 32'h400) begin fails++; $display("FAIL sync_epc got %h exp 400", o_epc); end tests++;
        if (o_exl !== 1'b1) begin fails++; $display("FAIL sync_exl got %b exp 1", o_exl); end tests++;
        rd(13, r); if (r[6:2] !== 5'd10) begin fails++; $display("FAIL sync_exccode got %0d exp 10", r[6:2]); end tests++;
        cyc;
        if (o_interrupt !== 1'b0) begin fails++; $display("FAIL sync_pulse_end got %b exp 0", o_interrupt); end tests++;
        overflow = 1; pc = 32'h999;
        cyc;
        overflow = 0;
        cyc;
        if (o_interrupt !== 1'b0 || o_epc !== 32'h400) begin
            fails++; $display("FAIL handler_drop got int=%b epc=%h exp int=0 epc=400", o_interrupt, o_epc);
        end tests++;
        eret = 1;
        cyc;
        eret = 0;
        if (o_exl !== 1'b0) begin fails++; $display("FAIL eret_exl got %b exp 0", o_exl); end tests++;
        cyc;
    endtask

    task automatic test_irq;
        logic [31:0] r;
        logic seen;
        irq = 6'b000001;
        mtc0(12, 32'h0400);
        rd(13, r); if (r[10] !== 1'b1) begin fails++; $display("FAIL irq_ip2 got %b exp 1", r[10]); end tests++;
        seen = 0;
        repeat (3) begin cyc; if (o_interrupt) seen = 1; end
        if (seen !== 1'b0) begin fails++; $display("FAIL irq_ie0 got pulse=%b exp 0", seen); end tests++;
        pc = 32'h500;
        mtc0(12, 32'h0401);
        cyc;
        rd(13, r);
        if (o_interrupt !== 1'b1 || r[6:2] !== 5'd0 || o_epc !== 32'h500) begin
            fails++; $display("FAIL irq_take got int=%b code=%0d epc=%h exp 1 0 500", o_interrupt, r[6:2], o_epc);
        end tests++;
        cyc;
        eret = 1;
        cyc;
        eret = 0;
        if (o_interrupt !== 1'b0 || o_exl !== 1'b0) begin
            fails++; $display("FAIL irq_eret got int=%b exl=%b exp 0 0", o_interrupt, o_exl);
        end tests++;
        cyc;
        if (o_interrupt !== 1'b0) begin fails++; $display("FAIL irq_ret_holdoff got %b exp 0", o_interrupt); end tests++;
        cyc;
        if (o_interrupt !== 1'b1) begin fails++; $display("FAIL irq_retake got %b exp 1", o_interrupt); end tests++;
        irq = '0;
        cyc;
        eret = 1;
        cyc;
        eret = 0;
        cyc;
        mtc0(12, 32'h0);
    endtask

    task automatic test_mtc0_race;
        overflow = 1; pc = 32'h800; we = 1; addr = 14; wdata = 32'h1234; mc0 = 1;
        #1;
        if (o_rdata !== 32'h500) begin fails++; $display("FAIL mfc0_old got %h exp 500", o_rdata); end tests++;
        cyc;
        overflow = 0; we = 0; mc0 = 0;
        if (o_epc !== 32'h800 || o_interrupt !== 1'b1) begin
            fails++; $display("FAIL race_epc got epc=%h int=%b exp 800 1", o_epc, o_interrupt);
        end tests++;
        cyc;
        eret = 1;
        cyc;
        eret = 0;
        cyc;
        mtc0(14, 32'h1234);
        if (o_epc !== 32'h1234) begin fails++; $display("FAIL mtc0_epc got %h exp 1234", o_epc); end tests++;
    endtask

    task automatic test_exl_mask;
        logic [31:0] r;
        logic seen;
        mtc0(12, 32'h2);
        if (o_exl !== 1'b1) begin fails++; $display("FAIL mask_exl got %b exp 1", o_exl); end tests++;
        overflow = 1;
        cyc;
        overflow = 0;
        seen = o_interrupt;
        cyc;
        if (seen !== 1'b0 || o_interrupt !== 1'b0 || o_epc !== 32'h1234) begin
            fails++; $display("FAIL mask_drop got int=%b epc=%h exp 0 1234", seen | o_interrupt, o_epc);
        end tests++;
        mtc0(12, 32'h0);
        mtc0(5, 32'hffff_ffff);
        rd(5, r); if (r !== 32'h0) begin fails++; $display("FAIL unimpl_reg got %h exp 0", r); end tests++;
        addr = 14; mc0 = 0;
        #1;
        if (o_rdata !== 32'h0) begin fails++; $display("FAIL rdata_idle got %h exp 0", o_rdata); end tests++;
    endtask

    task automatic test_timer;
        logic [31:0] r;
`ifdef COPROC0_TIMER_EN
        logic seen;
        mtc0(11, 32'd10);
        mtc0(9, 32'd0);
        mtc0(12, 32'h8001);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin cyc; seen = o_interrupt; end
        if (seen !== 1'b1) begin fails++; $display("FAIL timer_pulse got %b exp 1 within 40 cycles", seen); end tests++;
        rd(13, r); if (r[15] !== 1'b1) begin fails++; $display("FAIL timer_ip7 got %b exp 1", r[15]); end tests++;
        mtc0(11, 32'd5000);
        rd(13, r); if (r[15] !== 1'b0) begin fails++; $display("FAIL timer_clear got %b exp 0", r[15]); end tests++;
        eret = 1;
        cyc;
        eret = 0;
        cyc;
        mtc0(12, 32'h0);
`else
        mtc0(9, 32'd55);
        rd(9, r); if (r !== 32'h0) begin fails++; $display("FAIL no_timer_count got %h exp 0", r); end tests++;
`endif
    endtask

    task automatic test_async_reset;
        invalid = 1; pc = 32'h40;
        cyc;
        invalid = 0;
        cyc;
        if (o_exl !== 1'b1) begin fails++; $display("FAIL ar_exl_pre got %b exp 1", o_exl); end tests++;
        #2 rst_n = 0;
        #1;
        if (o_exl !== 1'b0 || o_epc !== 32'h0) begin
            fails++; $display("FAIL ar_clear got exl=%b epc=%h exp 0 0", o_exl, o_epc);
        end tests++;
        #2 rst_n = 1;
        overflow = 1;
        cyc;
        overflow = 0;
        if (o_interrupt !== 1'b1) begin fails++; $display("FAIL ar_run got %b exp 1", o_interrupt); end tests++;
    endtask

    initial begin
        test_reset;
        test_sync_exc;
        test_irq;
        test_mtc0_race;
        test_exl_mask;
        test_timer;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
